process_sequencer: RTL

- Sequential front/back-end for the 2-bit combinational process stage. Owns the state register r[1:0] that the stage consumes, and captures the stage's input b[1:0] under a valid strobe.
- Debounces the night input N and commits the stage result f[1:0] back into r after a fixed settle window.
- Sits directly around the process stage: its outputs drive r1/r0/b1/b0/N; f1/f0/l return as inputs.

---
 rtl/process_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/process_sequencer.sv
// process_sequencer: sequential wrapper around the 2-bit combinational
// process stage. Holds the state register r, latches operand b on request,
// waits a settle window, then commits the stage result f back into r.
// Also synchronizes and debounces the night input and registers the lamp.
//
// Optional build macro PROC_HIST_EN adds r_hist[7:0], a 4-deep shift
// history of the r values replaced by each commit.
module process_sequencer #(
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned DEB_LEN   = 4,
  parameter int unsigned CNT_W     = 8,
  parameter logic [1:0]  RST_STATE = 2'b00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       b_in,
  input  logic             b_valid,
  input  logic             night_in,
  input  logic [1:0]       f_in,
  input  logic             l_in,
  output logic [1:0]       r_out,
  output logic [1:0]       b_out,
  output logic             n_out,
  output logic             busy,
  output logic             done,
  output logic             lamp,
  output logic [CNT_W-1:0] step_count
`ifdef PROC_HIST_EN
  ,
  output logic [7:0]       r_hist
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] settle_cnt;

  logic       sync1;
  logic       ns;
  logic [7:0] deb_cnt;

  // Step sequencer: accept request in IDLE, hold operands, commit f_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      r_out      <= RST_STATE;
      b_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (b_valid) begin
            b_out      <= b_in;
            settle_cnt <= 4'(SETTLE - 1);
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= S_COMMIT;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_COMMIT: begin
          r_out      <= f_in;
          done       <= 1'b1;
          step_count <= step_count + CNT_W'(1);
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PROC_HIST_EN
  // History of r values displaced by each commit, newest in the low bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
    end else if (state == S_COMMIT) begin
      r_hist <= {r_hist[5:0], r_out};
    end
  end
`endif

  // Two-flop synchronizer for the asynchronous night input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      ns    <= 1'b0;
    end else begin
      sync1 <= night_in;
      ns    <= sync1;
    end
  end

  // Debounce: n_out follows ns only after DEB_LEN consecutive mismatching cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
      n_out   <= 1'b0;
    end else if (ns == n_out) begin
      deb_cnt <= '0;
    end else if (deb_cnt == 8'(DEB_LEN - 1)) begin
      n_out   <= ns;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  // Lamp is a one-cycle registered copy of the stage output.
  always_ff @(posedge clk) begin
    if (rst) begin
      lamp <= 1'b0;
    end else begin
      lamp <= l_in;
    end
  end

endmodule
